// File: rtl/irq_ctrl_n_pkg.sv
// Shared types and constants for the N-channel interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    VEC  = 2'd2
  } irq_state_e;

  localparam logic [1:0] CFG_ENABLE   = 2'd0;
  localparam logic [1:0] CFG_MODE     = 2'd1;
  localparam logic [1:0] CFG_PEND_CLR = 2'd2;

endpackage

// File: rtl/irq_ctrl_n_prio_enc.sv
// Lowest-set-index priority encoder: bit 0 has the highest priority.
module prio_enc #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]         vec,
  output logic                 valid,
  output logic [$clog2(W)-1:0] idx
);

  // Scan upward and keep only the first set bit found.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (vec[i] && !valid) begin
        valid = 1'b1;
        idx   = ($clog2(W))'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl_n.sv
// N-channel interrupt controller: per-channel enable and edge/level mode,
// fixed priority, nested preemption via in-service mask, req/ack/vector
// handshake towards the core and end-of-interrupt from RETI.
module irq_ctrl_n
  import irq_pkg::*;
#(
  parameter int unsigned         NUM_IRQ       = 8,
  parameter int unsigned         DATA_W        = 16,
  parameter logic [DATA_W-1:0]   VECTOR_BASE   = DATA_W'('h0064),
  parameter int unsigned         VECTOR_STRIDE = 2,
  parameter int unsigned         ID_W          = $clog2(NUM_IRQ)
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic [NUM_IRQ-1:0] I_irq,
  input  logic               I_global_en,
  input  logic               I_cfg_we,
  input  logic [1:0]         I_cfg_sel,
  input  logic [NUM_IRQ-1:0] I_cfg_data,
  input  logic               I_ack,
  input  logic               I_eoi,
  output logic               O_req,
  output logic [ID_W-1:0]    O_irq_id,
  output logic [DATA_W-1:0]  O_vector,
  output logic               O_vector_valid,
  output logic [NUM_IRQ-1:0] O_pending,
  output logic [NUM_IRQ-1:0] O_in_service
);

  irq_state_e         state, state_nxt;
  logic [ID_W-1:0]    irq_id, irq_id_nxt;

  logic [NUM_IRQ-1:0] pending, pending_nxt;
  logic [NUM_IRQ-1:0] enable, enable_nxt;
  logic [NUM_IRQ-1:0] mode, mode_nxt;
  logic [NUM_IRQ-1:0] in_service, in_service_nxt;
  logic [NUM_IRQ-1:0] prev_irq;

  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] edge_clr;
  logic [NUM_IRQ-1:0] id_onehot;
  logic [NUM_IRQ-1:0] is_after_eoi;

  logic               win_valid;
  logic [ID_W-1:0]    win_idx;
  logic               is_valid;
  logic [ID_W-1:0]    is_idx;
  logic               allowed;

  assign eligible  = pending & enable & ~in_service;
  assign rise      = I_irq & ~prev_irq;
  assign id_onehot = NUM_IRQ'(1) << irq_id;

  prio_enc #(.W(NUM_IRQ)) u_win_enc (
    .vec   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  prio_enc #(.W(NUM_IRQ)) u_is_enc (
    .vec   (in_service),
    .valid (is_valid),
    .idx   (is_idx)
  );

  // A winner may only preempt a strictly lower-priority in-service channel.
  assign allowed = win_valid && (!is_valid || (win_idx < is_idx));

  // Handshake state and latched channel id.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state  <= IDLE;
      irq_id <= '0;
    end else begin
      state  <= state_nxt;
      irq_id <= irq_id_nxt;
    end
  end

  // Next-state logic; the id is only re-latched when leaving IDLE.
  always_comb begin
    state_nxt  = state;
    irq_id_nxt = irq_id;
    unique case (state)
      IDLE: begin
        if (I_global_en && allowed) begin
          state_nxt  = REQ;
          irq_id_nxt = win_idx;
        end
      end
      REQ: begin
        if (I_ack) begin
          state_nxt = VEC;
        end else if (!I_global_en) begin
          state_nxt = IDLE;
        end
      end
      VEC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pending/config/in-service next values. Edge-mode clears come from W1C and
  // the vector cycle; a simultaneous rising edge wins. EOI is applied to the
  // old in-service mask before the vector cycle sets its bit.
  always_comb begin
    edge_clr = '0;
    if (I_cfg_we && (I_cfg_sel == CFG_PEND_CLR)) begin
      edge_clr = I_cfg_data;
    end
    if (state == VEC) begin
      edge_clr = edge_clr | id_onehot;
    end

    pending_nxt = (mode & ((pending & ~edge_clr) | rise)) | (~mode & I_irq);

    enable_nxt = enable;
    mode_nxt   = mode;
    if (I_cfg_we && (I_cfg_sel == CFG_ENABLE)) begin
      enable_nxt = I_cfg_data;
    end
    if (I_cfg_we && (I_cfg_sel == CFG_MODE)) begin
      mode_nxt = I_cfg_data;
    end

    is_after_eoi = in_service;
    if (I_eoi) begin
      is_after_eoi = in_service & (in_service - NUM_IRQ'(1));
    end
    in_service_nxt = is_after_eoi;
    if (state == VEC) begin
      in_service_nxt = is_after_eoi | id_onehot;
    end
  end

  // Channel registers.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      pending    <= '0;
      enable     <= '0;
      mode       <= '0;
      in_service <= '0;
      prev_irq   <= '0;
    end else begin
      pending    <= pending_nxt;
      enable     <= enable_nxt;
      mode       <= mode_nxt;
      in_service <= in_service_nxt;
      prev_irq   <= I_irq;
    end
  end

  assign O_req          = (state == REQ);
  assign O_vector_valid = (state == VEC);
  assign O_irq_id       = irq_id;
  assign O_vector       = VECTOR_BASE + (DATA_W'(irq_id) * DATA_W'(VECTOR_STRIDE));
  assign O_pending      = pending;
  assign O_in_service   = in_service;

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Self-checking bench for irq_ctrl_n: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the controller.
module tb_irq_ctrl_n;

  localparam int N = 8;

  logic         I_clk = 1'b0;
  logic         I_reset;
  logic [N-1:0] I_irq;
  logic         I_global_en;
  logic         I_cfg_we;
  logic [1:0]   I_cfg_sel;
  logic [N-1:0] I_cfg_data;
  logic         I_ack;
  logic         I_eoi;
  logic         O_req;
  logic [2:0]   O_irq_id;
  logic [15:0]  O_vector;
  logic         O_vector_valid;
  logic [N-1:0] O_pending;
  logic [N-1:0] O_in_service;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl_n #(
    .NUM_IRQ       (8),
    .DATA_W        (16),
    .VECTOR_BASE   (16'h0064),
    .VECTOR_STRIDE (2)
  ) dut (
    .I_clk          (I_clk),
    .I_reset        (I_reset),
    .I_irq          (I_irq),
    .I_global_en    (I_global_en),
    .I_cfg_we       (I_cfg_we),
    .I_cfg_sel      (I_cfg_sel),
    .I_cfg_data     (I_cfg_data),
    .I_ack          (I_ack),
    .I_eoi          (I_eoi),
    .O_req          (O_req),
    .O_irq_id       (O_irq_id),
    .O_vector       (O_vector),
    .O_vector_valid (O_vector_valid),
    .O_pending      (O_pending),
    .O_in_service   (O_in_service)
  );

  always #5 I_clk = ~I_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 = idle, 1 = requesting, 2 = vector cycle.
  bit [N-1:0] m_pend, m_en, m_mode, m_is, m_prev;
  int         m_phase = 0;
  int         m_id = 0;
  bit         model_valid = 0;

  function automatic int lowest(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge I_clk) begin
    automatic bit [N-1:0] rise, clr, np, nis, nen, nmode;
    automatic int nphase, nid, w, s;
    if (I_reset) begin
      m_pend <= '0; m_en <= '0; m_mode <= '0; m_is <= '0; m_prev <= '0;
      m_phase <= 0; m_id <= 0; model_valid <= 1;
    end else begin
      rise = I_irq & ~m_prev;
      clr  = (I_cfg_we && I_cfg_sel == 2'd2) ? I_cfg_data : '0;
      if (m_phase == 2) clr[m_id] = 1'b1;
      for (int i = 0; i < N; i++)
        np[i] = m_mode[i] ? ((m_pend[i] & ~clr[i]) | rise[i]) : I_irq[i];
      nis = m_is;
      if (I_eoi) begin
        s = lowest(m_is);
        if (s >= 0) nis[s] = 1'b0;
      end
      if (m_phase == 2) nis[m_id] = 1'b1;
      nphase = m_phase;
      nid = m_id;
      if (m_phase == 0) begin
        w = lowest(m_pend & m_en & ~m_is);
        s = lowest(m_is);
        if (I_global_en && w >= 0 && (s < 0 || w < s)) begin
          nphase = 1;
          nid = w;
        end
      end else if (m_phase == 1) begin
        if (I_ack) nphase = 2;
        else if (!I_global_en) nphase = 0;
      end else begin
        nphase = 0;
      end
      nen   = (I_cfg_we && I_cfg_sel == 2'd0) ? I_cfg_data : m_en;
      nmode = (I_cfg_we && I_cfg_sel == 2'd1) ? I_cfg_data : m_mode;
      m_pend <= np; m_is <= nis; m_en <= nen; m_mode <= nmode;
      m_prev <= I_irq; m_phase <= nphase; m_id <= nid;
    end
  end

  // Single compare process: every cycle once the model has seen a reset.
  always @(negedge I_clk) begin
    if (model_valid) begin
      chk("req",       O_req,          m_phase == 1);
      chk("vec_valid", O_vector_valid, m_phase == 2);
      chk("irq_id",    O_irq_id,       m_id);
      chk("vector",    O_vector,       16'(16'h0064 + m_id * 2));
      chk("pending",   O_pending,      m_pend);
      chk("in_service", O_in_service,  m_is);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge I_clk);
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [N-1:0] data);
    I_cfg_we = 1'b1; I_cfg_sel = sel; I_cfg_data = data;
    tick();
    I_cfg_we = 1'b0;
  endtask

  task automatic wait_req(input int max);
    for (int k = 0; k < max; k++) begin
      tick();
      if (O_req) break;
    end
    chk("req_seen", O_req, 1'b1);
  endtask

  task automatic ack_cycle();
    I_ack = 1'b1; tick(); I_ack = 1'b0;
  endtask

  task automatic eoi_cycle();
    I_eoi = 1'b1; tick(); I_eoi = 1'b0;
  endtask

  initial begin
    I_reset = 1'b1; I_irq = '0; I_global_en = 1'b0; I_cfg_we = 1'b0;
    I_cfg_sel = '0; I_cfg_data = '0; I_ack = 1'b0; I_eoi = 1'b0;
    tick(); tick();
    I_reset = 1'b0;
    chk("rst_req", O_req, 1'b0);
    chk("rst_vector", O_vector, 16'h0064);
    chk("rst_pending", O_pending, 8'h00);
    chk("rst_is", O_in_service, 8'h00);

    // Level channel 3.
    cfg(2'd0, 8'hFF);
    I_irq = 8'h08; I_global_en = 1'b1;
    wait_req(6);
    chk("lvl_id", O_irq_id, 3);
    ack_cycle();
    chk("lvl_vv", O_vector_valid, 1'b1);
    chk("lvl_vec", O_vector, 16'h006A);
    tick();
    chk("lvl_is", O_in_service, 8'h08);
    I_irq = '0;
    eoi_cycle();

    // Edge channel 5.
    I_global_en = 1'b0;
    cfg(2'd1, 8'h20);
    I_irq = 8'h20; tick(); I_irq = '0; tick();
    chk("edge_pend", O_pending, 8'h20);
    I_global_en = 1'b1;
    wait_req(6);
    chk("edge_id", O_irq_id, 5);
    ack_cycle();
    chk("edge_vec", O_vector, 16'h006E);
    tick();
    chk("edge_clr", O_pending, 8'h00);
    I_irq = 8'h20; tick(); I_irq = '0; tick(); tick();
    chk("edge_repend", O_pending, 8'h20);
    chk("edge_blocked", O_req, 1'b0);
    eoi_cycle();
    wait_req(6);
    chk("edge_reid", O_irq_id, 5);
    ack_cycle(); tick();
    eoi_cycle();

    // Nesting: ch4 in service, ch2 preempts, ch6 blocked.
    I_irq = 8'h10;
    wait_req(6);
    ack_cycle(); tick();
    I_irq = 8'h14;
    wait_req(6);
    chk("nest_id", O_irq_id, 2);
    ack_cycle();
    chk("nest_vec", O_vector, 16'h0068);
    tick();
    chk("nest_is", O_in_service, 8'h14);
    I_irq = 8'h50;
    tick(); tick(); tick(); tick();
    chk("nest_block", O_req, 1'b0);
    I_irq = '0;
    eoi_cycle(); eoi_cycle();
    chk("nest_is0", O_in_service, 8'h00);

    // Simultaneous ch0/ch1.
    I_irq = 8'h03;
    wait_req(6);
    chk("sim_id0", O_irq_id, 0);
    ack_cycle(); tick();
    I_irq = 8'h02;
    eoi_cycle();
    wait_req(6);
    chk("sim_id1", O_irq_id, 1);
    ack_cycle(); tick();
    I_irq = '0;
    eoi_cycle();

    // Withdraw via global enable, then reissue.
    I_irq = 8'h08;
    wait_req(6);
    I_global_en = 1'b0; tick();
    chk("wd_req", O_req, 1'b0);
    chk("wd_is", O_in_service, 8'h00);
    I_global_en = 1'b1;
    wait_req(6);
    chk("wd_reid", O_irq_id, 3);

    // Reset while requesting.
    I_reset = 1'b1; tick(); I_reset = 1'b0;
    chk("rr_req", O_req, 1'b0);
    chk("rr_pend", O_pending, 8'h00);
    tick(); tick();
    chk("rr_noen", O_req, 1'b0);

    // Edge and W1C on the same bit in the same cycle: set wins.
    I_irq = '0; I_global_en = 1'b0;
    cfg(2'd1, 8'h20);
    I_irq = 8'h20; I_cfg_we = 1'b1; I_cfg_sel = 2'd2; I_cfg_data = 8'h20;
    tick();
    I_cfg_we = 1'b0; I_irq = '0;
    tick();
    chk("w1c_setwins", O_pending, 8'h20);
    cfg(2'd2, 8'hFF);
    chk("w1c_clr", O_pending, 8'h00);

    // Randomized traffic.
    cfg(2'd0, 8'hFF);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) I_irq = 8'($urandom);
      I_global_en = ($urandom_range(0, 7) != 0);
      I_ack       = ($urandom_range(0, 1) == 1);
      I_eoi       = ($urandom_range(0, 5) == 0);
      I_cfg_we    = ($urandom_range(0, 11) == 0);
      I_cfg_sel   = 2'($urandom);
      I_cfg_data  = 8'($urandom);
      I_reset     = ($urandom_range(0, 499) == 0);
      tick();
    end
    I_reset = 1'b0; I_cfg_we = 1'b0; I_ack = 1'b0; I_eoi = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
